// File: rtl/pipe_addsub_pkg.sv
// Shared elaboration helpers for the pipelined adder/subtractor:
// chunk-width derivation and parameter legality.
package pipe_addsub_pkg;

  function automatic int unsigned chunk_of(int unsigned width, int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  function automatic bit params_legal(int unsigned width, int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
// cmsb is the carry into the top bit, used for signed overflow.
module addsub_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry
// registered between stages, valid/ready handshake with a single global advance.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned CHUNK = chunk_of(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $fatal(1, "pipe_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Per-stage registers: operand delay lines, partial sum, inter-stage carry, valid.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];
  logic             ovf_q;

  // Stage inputs: the port operands for stage 0, the predecessor registers otherwise.
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] sum_in [STAGES];
  logic             c_in   [STAGES];
  logic             v_in   [STAGES];

  logic adv;

  assign adv      = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] s_k;
    logic             co_k;
    logic             cm_k;
    logic [WIDTH-1:0] sum_nx;

    if (k == 0) begin : g_head
      assign a_in[k]   = in_a;
      assign b_in[k]   = in_sub ? ~in_b : in_b;
      assign c_in[k]   = in_sub ? ~in_cin : in_cin;
      assign sum_in[k] = '0;
      assign v_in[k]   = in_valid;
    end else begin : g_body
      assign a_in[k]   = a_q[k-1];
      assign b_in[k]   = b_q[k-1];
      assign c_in[k]   = c_q[k-1];
      assign sum_in[k] = sum_q[k-1];
      assign v_in[k]   = v_q[k-1];
    end

    addsub_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .a   (a_in[k][k*CHUNK +: CHUNK]),
      .b   (b_in[k][k*CHUNK +: CHUNK]),
      .cin (c_in[k]),
      .s   (s_k),
      .cout(co_k),
      .cmsb(cm_k)
    );

    always_comb begin
      sum_nx                    = sum_in[k];
      sum_nx[k*CHUNK +: CHUNK]  = s_k;
    end

    // Data only moves with a valid token so bubbles leave registers untouched.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
      end else if (adv) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          a_q[k]   <= a_in[k];
          b_q[k]   <= b_in[k];
          sum_q[k] <= sum_nx;
          c_q[k]   <= co_k;
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv && v_in[k]) begin
          ovf_q <= co_k ^ cm_k;
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub (WIDTH=8, STAGES=2) plus a random stream
// through STAGES=1, 4 and 8 instances checked against a reference model.
module tb_pipe_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_cin;
  logic       in_sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_cout;
  logic       out_ovf;

  logic       r_valid;
  logic       r_in_ready [3];
  logic       r_ov       [3];
  logic [7:0] r_sum      [3];
  logic       r_co       [3];
  logic       r_of       [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  pipe_addsub #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(r_in_ready[0]), .in_a(in_a),
    .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .out_valid(r_ov[0]), .out_ready(1'b1),
    .out_sum(r_sum[0]), .out_cout(r_co[0]), .out_ovf(r_of[0])
  );

  pipe_addsub #(.WIDTH(8), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(r_in_ready[1]), .in_a(in_a),
    .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .out_valid(r_ov[1]), .out_ready(1'b1),
    .out_sum(r_sum[1]), .out_cout(r_co[1]), .out_ovf(r_of[1])
  );

  pipe_addsub #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(r_in_ready[2]), .in_a(in_a),
    .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .out_valid(r_ov[2]), .out_ready(1'b1),
    .out_sum(r_sum[2]), .out_cout(r_co[2]), .out_ovf(r_of[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    logic [7:0] be;
    logic       ce;
    logic [8:0] f;
    logic       ov;
    be = sub ? ~b : b;
    ce = sub ? ~cin : cin;
    f  = {1'b0, a} + {1'b0, be} + {8'd0, ce};
    ov = (a[7] == be[7]) && (f[7] != a[7]);
    return {ov, f[8], f[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub, input logic [7:0] es,
                        input logic ec, input logic eo);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    chk({tag, "/in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "/early_valid"}, out_valid, 0);
    tick();
    chk({tag, "/valid"}, out_valid, 1);
    chk({tag, "/sum"}, out_sum, es);
    chk({tag, "/cout"}, out_cout, ec);
    chk({tag, "/ovf"}, out_ovf, eo);
    tick();
    chk({tag, "/drained"}, out_valid, 0);
  endtask

  task automatic run_stream(input string tag, input int n, input int stall_at,
                            input int stall_len);
    logic [9:0] q[$];
    logic [9:0] held;
    logic       held_ok;
    logic [9:0] m;
    int         sent;
    int         got;
    sent = 0; got = 0; held_ok = 1'b0; held = '0;
    for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = (sent < n);
      in_a      = 8'(sent * 37 + 5);
      in_b      = 8'(sent * 91 + 200);
      in_cin    = sent[0];
      in_sub    = sent[1];
      #1;
      if (held_ok) chk({tag, "/stable"}, {out_ovf, out_cout, out_sum}, held);
      if (stall_len == 0) begin
        chk({tag, "/in_ready"}, in_ready, 1);
        if (cyc >= 2 && cyc < n + 2) chk({tag, "/back_to_back"}, out_valid, 1);
      end
      if (out_valid && out_ready) begin
        if (q.size() > 0) begin
          chk({tag, "/data"}, {out_ovf, out_cout, out_sum}, q.pop_front());
          got++;
        end else begin
          chk({tag, "/unexpected"}, out_valid, 0);
        end
      end
      if (out_valid && !out_ready) begin
        chk({tag, "/stall_ready"}, in_ready, 0);
        held    = {out_ovf, out_cout, out_sum};
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (in_valid && in_ready) begin
        m = model(in_a, in_b, in_cin, in_sub);
        q.push_back(m);
        sent++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "/count"}, got, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] q1[$];
    logic [9:0] q4[$];
    logic [9:0] q8[$];
    logic [9:0] m;

    rst = 1'b1; in_valid = 1'b0; r_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset/valid", out_valid, 0);
    chk("reset/sum", out_sum, 0);
    chk("reset/cout", out_cout, 0);
    chk("reset/ovf", out_ovf, 0);
    chk("reset/in_ready", in_ready, 1);

    single("add_3c_05", 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);
    single("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    single("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    single("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    single("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    single("sub_05_03_b", 8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);

    run_stream("stream6", 6, 1000, 0);
    run_stream("stall4", 8, 3, 4);

    // Reset with two transactions in flight, the older one stalled at the output.
    in_a = 8'h11; in_b = 8'h22; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_a = 8'h33; in_b = 8'h44; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("rst_mid/full", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    chk("rst_mid/valid", out_valid, 0);
    chk("rst_mid/sum", out_sum, 0);
    chk("rst_mid/cout", out_cout, 0);
    chk("rst_mid/ovf", out_ovf, 0);
    chk("rst_mid/in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid/no_stale", out_valid, 0);
    end

    // Random stream through the STAGES=1/4/8 instances.
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (r_ov[0]) begin
        if (q1.size() > 0) chk("rand_s1", {r_of[0], r_co[0], r_sum[0]}, q1.pop_front());
        else chk("rand_s1_extra", r_ov[0], 0);
      end
      if (r_ov[1]) begin
        if (q4.size() > 0) chk("rand_s4", {r_of[1], r_co[1], r_sum[1]}, q4.pop_front());
        else chk("rand_s4_extra", r_ov[1], 0);
      end
      if (r_ov[2]) begin
        if (q8.size() > 0) chk("rand_s8", {r_of[2], r_co[2], r_sum[2]}, q8.pop_front());
        else chk("rand_s8_extra", r_ov[2], 0);
      end
      chk("rand_s8_ready", r_in_ready[2], 1);
      r_valid = (cyc < 48) && ($urandom_range(0, 3) != 0);
      in_a    = 8'($urandom);
      in_b    = 8'($urandom);
      in_cin  = 1'($urandom);
      in_sub  = 1'($urandom);
      if (r_valid) begin
        m = model(in_a, in_b, in_cin, in_sub);
        q1.push_back(m);
        q4.push_back(m);
        q8.push_back(m);
      end
      tick();
    end
    r_valid = 1'b0;
    chk("rand_s1_drain", q1.size(), 0);
    chk("rand_s4_drain", q4.size(), 0);
    chk("rand_s8_drain", q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
Parametrised, pipelined ripple-carry adder/subtractor that generalises the team's fixed 4-bit adder. The operand width is split into STAGES equal chunks, and each chunk is added in its own pipeline stage, with the carry registered between stages. Valid/ready handshakes on input and output allow the block to sit between streaming datapath units, for example as the accumulator front-end of the DSP chain. Per-transaction add/sub mode, carry-out and signed overflow are provided.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages; each stage adds CHUNK = WIDTH/STAGES bits; legal range 1..WIDTH.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand transaction present
in_ready  output  1  block accepts the transaction this cycle
in_a  input  WIDTH  operand A, unsigned/two's complement
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in (add) / borrow-in (sub)
in_sub  input  1  0: A+B+cin; 1: A-B-cin
out_valid  output  1  result present
out_ready  input  1  downstream accepts the result
out_sum  output  WIDTH  result, modulo 2^WIDTH
out_cout  output  1  raw carry out of the MSB (sub: 1 = no borrow)
out_ovf  output  1  signed two's-complement overflow

Behaviour:
- Arithmetic: the effective B is in_sub ? ~in_b : in_b, and the effective cin is in_sub ? ~in_cin : in_cin.
- Result: sum = A + Beff + cineff, computed over WIDTH+1 bits. out_cout is bit WIDTH of that sum. out_ovf = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]).
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of A and Beff with the carry from stage k-1. Stage 0 uses cineff.
- Skew: upper operand chunks travel down delay registers until their stage. Lower sum chunks are carried forward alongside them until the output stage.
- Each stage holds a valid bit v[k]. Stage STAGES-1 drives the out_* outputs directly from its registers.
- Global advance: adv = !v[STAGES-1] || out_ready. When adv=1, every stage loads from its predecessor, and stage 0 loads in_valid and the operands. When adv=0, all stage registers hold.
- in_ready = adv, which is combinational from out_ready and v[STAGES-1]. A transfer occurs when in_valid && in_ready.
- Latency: an accepted transaction appears on out_valid exactly STAGES cycles later when not stalled.
- Throughput: one transaction per cycle while out_ready stays high.
- Bubbles are not collapsed. An empty middle stage still advances only with adv, which is acceptable because adv is high whenever the output is empty.
- While out_valid=1 && out_ready=0, out_sum, out_cout and out_ovf stay stable.
- in_a, in_b, in_cin and in_sub are sampled only when a transfer occurs. Values while in_ready=0 are don't-care.
- Reset: all v[k]=0, all data registers = 0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0. Reset takes priority over adv.
- Reset mid-operation: in-flight transactions are discarded with no partial output. in_ready=1 from the first cycle after reset.
- Width rules: there is no saturation, and the sum wraps modulo 2^WIDTH.
- STAGES=1 degenerates to a single registered adder with latency 1. STAGES=WIDTH gives one bit per stage.
- Elaboration check: WIDTH % STAGES != 0 is a fatal elaboration error.

Decomposition:
- No shared package types are required. The CHUNK derivation and the parameter legality check live in pipe_addsub_pkg for reuse by the bench.
- One natural sub-module: addsub_slice, a combinational CHUNK-bit ripple adder with a, b, cin, s, cout and cmsb (the carry into its MSB, used for overflow). It is built from the existing full_adder cell and instantiated once per stage with a generate loop.

Test Plan:
1. WIDTH=8, STAGES=2, add 0x3C+0x05, cin=0 -> out_sum=0x41, cout=0, ovf=0; out_valid rises exactly 2 cycles after acceptance.
2. Add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1. Add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. Both results exercise the carry across the stage boundary.
3. Sub 0x10-0x20, cin=0 -> sum=0xF0, cout=0 (borrow), ovf=0. Sub 0x80-0x01 -> sum=0x7F, ovf=1. Sub 0x05-0x03 with cin=1 -> sum=0x01, cout=1.
4. Stream 6 back-to-back transactions with out_ready=1 -> 6 consecutive out_valid cycles in order, in_ready constantly 1.
5. Hold out_ready=0 for 4 cycles mid-stream -> in_ready drops once the pipe is full, the output stays stable and no data is lost or duplicated. On release, the remaining results arrive in order.
6. Assert rst for 1 cycle with 2 transactions in flight -> out_valid=0 with all outputs 0 the next cycle, no stale result ever emitted, and in_ready=1 after reset. Random compare against a reference model also runs for STAGES=1, 4 and 8 at WIDTH=8.
